// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for a 5-stage MIPS pipeline with branches resolved in ID.
// Decodes load-use and branch-operand hazards and freezes the pipe around slow
// data-memory accesses. A stuck access ends in a sticky error state.
// Optional build macro: HAZ_PERF_EN adds saturating stall/flush/wait counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_take,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_wreg,
    input  logic             mem_memread,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             dmem_req,
    output logic             hz_error
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    typedef enum logic [1:0] {StInit, StRun, StMemWait, StError} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       lu, bex, bmm, stall, advance;

    // Hazard terms; register 0 never creates a dependency.
    always_comb begin
        lu    = ex_memread && (ex_wreg != 5'd0) &&
                ((ex_wreg == id_rs) || (id_use_rt && (ex_wreg == id_rt)));
        bex   = id_branch && ex_regwrite && (ex_wreg != 5'd0) &&
                ((ex_wreg == id_rs) || (ex_wreg == id_rt));
        bmm   = id_branch && mem_memread && (mem_wreg != 5'd0) &&
                ((mem_wreg == id_rs) || (mem_wreg == id_rt));
        stall = lu || bex || bmm;
    end

    // State and wait-counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state: a missing dmem_ready parks the pipe in StMemWait until it arrives or times out.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (mem_access && !dmem_ready) begin
                    state_d = StMemWait;
                    wait_d  = 8'd0;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StError: state_d = StError;
            default: state_d = StInit;
        endcase
    end

    // Outputs: memory freeze beats stall, stall beats branch flush.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
        dmem_req    = 1'b0;
        hz_error    = 1'b0;
        advance     = ((state_q == StRun) && (!mem_access || dmem_ready)) ||
                      ((state_q == StMemWait) && dmem_ready);
        if (state_q == StInit) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
        if (state_q == StError) hz_error = 1'b1;
        dmem_req = ((state_q == StRun) && mem_access) || (state_q == StMemWait);
        if (advance) begin
            exmem_write = 1'b1;
            memwb_write = 1'b1;
            if (stall) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = id_take;
            end
        end
    end

`ifdef HAZ_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (state_q == StRun && advance && stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (state_q == StRun && ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
            if (state_q == StMemWait && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (default build, MEM_TIMEOUT=4).
// Output vector order: pc, ifid, flush, bubble, exmem, memwb, req, error.
module tb_pipe_hazard_ctrl;
    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
    logic       id_use_rt, id_branch, id_take, ex_memread, ex_regwrite;
    logic       mem_memread, mem_access, dmem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble;
    logic       exmem_write, memwb_write, dmem_req, hz_error;
    logic [7:0] outs;
    logic [7:0] exp_v;
    int         n_chk = 0;
    int         n_fail = 0;

    // Reference model: pipeline mode flags and count of unanswered wait cycles.
    bit m_init, m_err, m_wait;
    int m_wcnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_take(id_take), .ex_memread(ex_memread),
        .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg), .mem_memread(mem_memread),
        .mem_wreg(mem_wreg), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_write(exmem_write), .memwb_write(memwb_write),
        .dmem_req(dmem_req), .hz_error(hz_error)
    );

    assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble,
                   exmem_write, memwb_write, dmem_req, hz_error};

    always #5 clk = ~clk;

    function automatic bit reads(input logic [4:0] r, input bit use_rt);
        return (r != 5'd0) && ((r == id_rs) || (use_rt && (r == id_rt)));
    endfunction

    function automatic bit model_stall();
        return (ex_memread && reads(ex_wreg, id_use_rt)) ||
               (id_branch && ex_regwrite && reads(ex_wreg, 1'b1)) ||
               (id_branch && mem_memread && reads(mem_wreg, 1'b1));
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        bit go;
        o = 8'b0;
        if (reset || m_init) return 8'b0011_0000;
        if (m_err) return 8'b0000_0001;
        o[1] = m_wait || mem_access;
        go = m_wait ? dmem_ready : (!mem_access || dmem_ready);
        if (go) begin
            o[3] = 1'b1;
            o[2] = 1'b1;
            if (model_stall()) o[4] = 1'b1;
            else begin
                o[7] = 1'b1;
                o[6] = 1'b1;
                o[5] = id_take;
            end
        end
        return o;
    endfunction

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rt = 0; id_branch = 0; id_take = 0;
        ex_memread = 0; ex_regwrite = 0; ex_wreg = 0;
        mem_memread = 0; mem_wreg = 0; mem_access = 0; dmem_ready = 0;
    endtask

    // Clock edge plus model update; returns 1 time unit after the edge.
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_init = 1; m_err = 0; m_wait = 0; m_wcnt = 0;
        end else if (m_init) begin
            m_init = 0;
        end else if (!m_err) begin
            if (m_wait) begin
                if (dmem_ready) m_wait = 0;
                else if (m_wcnt + 1 == TO) begin
                    m_err = 1; m_wait = 0;
                end else m_wcnt++;
            end else if (mem_access && !dmem_ready) begin
                m_wait = 1; m_wcnt = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #2;
        exp_v = 8'b0011_0000; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rst_async: got %b want %b", outs, exp_v); end
        adv();
        reset = 1'b0;
        @(negedge clk);
        exp_v = 8'b0011_0000; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rst_init: got %b want %b", outs, exp_v); end
        adv();
        @(negedge clk);
        exp_v = 8'b1100_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL rst_run: got %b want %b", outs, exp_v); end
        adv();
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 2; id_rs = 2; id_rt = 4; id_use_rt = 1;
        @(negedge clk);
        exp_v = 8'b0001_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lu_stall: got %b want %b", outs, exp_v); end
        adv();
        ex_memread = 0; ex_regwrite = 0; ex_wreg = 0; mem_memread = 1; mem_wreg = 2;
        @(negedge clk);
        exp_v = 8'b1100_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lu_release: got %b want %b", outs, exp_v); end
        adv();
        idle();
        ex_memread = 1; ex_wreg = 0; id_rs = 0; id_rt = 0; id_use_rt = 1;
        @(negedge clk);
        exp_v = 8'b1100_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lu_reg0: got %b want %b", outs, exp_v); end
        adv();
    endtask

    task automatic test_branch();
        idle();
        id_branch = 1; id_rs = 5; id_rt = 6; id_use_rt = 1; ex_regwrite = 1; ex_wreg = 5;
        @(negedge clk);
        exp_v = 8'b0001_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL br_ex: got %b want %b", outs, exp_v); end
        adv();
        ex_regwrite = 0; ex_wreg = 0; mem_memread = 1; mem_wreg = 6;
        @(negedge clk);
        exp_v = 8'b0001_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL br_mem: got %b want %b", outs, exp_v); end
        adv();
        mem_memread = 0; mem_wreg = 0; id_take = 1;
        @(negedge clk);
        exp_v = 8'b1110_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL br_flush: got %b want %b", outs, exp_v); end
        adv();
    endtask

    task automatic test_memwait();
        idle();
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = 8'b0000_0010; n_chk++;
            if (outs !== exp_v) begin
                n_fail++; $display("FAIL mw_freeze%0d: got %b want %b", i, outs, exp_v);
            end
            adv();
        end
        dmem_ready = 1;
        @(negedge clk);
        exp_v = 8'b1100_1110; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL mw_release: got %b want %b", outs, exp_v); end
        adv();
        mem_access = 0; dmem_ready = 0;
        @(negedge clk);
        exp_v = 8'b1100_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL mw_after: got %b want %b", outs, exp_v); end
        adv();
        // Reset during a pending access must drop the request without a clock edge.
        mem_access = 1;
        adv();
        mem_access = 0;
        #1;
        exp_v = 8'b0000_0010; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL mw_hold: got %b want %b", outs, exp_v); end
        reset = 1;
        #1;
        n_chk++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mw_rst_req: got %b want 0", dmem_req); end
        adv();
        reset = 0;
        adv();
    endtask

    task automatic test_timeout();
        idle();
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 1 + TO; i++) begin
            @(negedge clk);
            exp_v = 8'b0000_0010; n_chk++;
            if (outs !== exp_v) begin
                n_fail++; $display("FAIL to_wait%0d: got %b want %b", i, outs, exp_v);
            end
            adv();
        end
        @(negedge clk);
        exp_v = 8'b0000_0001; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL to_error: got %b want %b", outs, exp_v); end
        adv();
        mem_access = 0; dmem_ready = 1;
        adv();
        @(negedge clk);
        exp_v = 8'b0000_0001; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL to_sticky: got %b want %b", outs, exp_v); end
        reset = 1;
        adv();
        reset = 0;
        @(negedge clk);
        exp_v = 8'b0011_0000; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL to_reinit: got %b want %b", outs, exp_v); end
        adv();
    endtask

    task automatic test_stall_take();
        idle();
        ex_memread = 1; ex_wreg = 7; id_rs = 7; id_take = 1;
        @(negedge clk);
        exp_v = 8'b0001_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL st_take: got %b want %b", outs, exp_v); end
        adv();
        ex_memread = 0; ex_wreg = 0;
        @(negedge clk);
        exp_v = 8'b1110_1100; n_chk++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL st_flush_next: got %b want %b", outs, exp_v); end
        adv();
    endtask

    task automatic test_random();
        idle();
        reset = 1;
        adv();
        reset = 0;
        for (int i = 0; i < 600; i++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rt   = 1'($urandom);
            id_branch   = 1'($urandom);
            id_take     = 1'($urandom);
            ex_memread  = 1'($urandom);
            ex_regwrite = 1'($urandom);
            ex_wreg     = 5'($urandom_range(0, 3));
            mem_memread = 1'($urandom);
            mem_wreg    = 5'($urandom_range(0, 3));
            mem_access  = ($urandom_range(0, 3) == 0);
            dmem_ready  = ($urandom_range(0, 3) != 0);
            reset       = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            exp_v = model_out(); n_chk++;
            if (outs !== exp_v) begin
                n_fail++; $display("FAIL rand%0d: got %b want %b", i, outs, exp_v);
            end
            adv();
        end
        reset = 0;
    endtask

    initial begin
        m_init = 1; m_err = 0; m_wait = 0; m_wcnt = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_memwait();
        test_timeout();
        test_stall_take();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
